// File: rtl/adc_scan_sched_pkg.sv
// Shared constants and helpers for the ADC scan scheduler.
// Holds the datapath widths (ADC sample, accumulator, tick period), the FSM
// state encoding and two small helpers used by the top-level FSM.
package adc_scan_sched_pkg;

    localparam int ADC_W  = 12;   // conversion result width
    localparam int ACC_W  = 15;   // accumulator: 8 x 12-bit samples cannot overflow
    localparam int PER_W  = 29;   // tick period register width
    localparam int NAVG_W = 2;    // log2 of averaging depth
    localparam int CNT_W  = 3;    // sample counter, 0..7

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_WAIT  = 3'd1;
    localparam state_t ST_START = 3'd2;
    localparam state_t ST_BUSY  = 3'd3;
    localparam state_t ST_ACC   = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

    // Index of the last sample in an averaging block: 2^navg - 1.
    function automatic logic [CNT_W-1:0] last_sample(input logic [NAVG_W-1:0] navg);
        logic [CNT_W:0] one_hot;
        one_hot = (CNT_W+1)'(1) << navg;
        return CNT_W'(one_hot - (CNT_W+1)'(1));
    endfunction

    // Truncating divide of an accumulator by 2^navg, narrowed to a sample.
    function automatic logic [ADC_W-1:0] avg_shift(input logic [ACC_W-1:0] acc,
                                                   input logic [NAVG_W-1:0] navg);
        logic [ACC_W-1:0] shifted;
        shifted = acc >> navg;
        return shifted[ADC_W-1:0];
    endfunction

endpackage

// File: rtl/adc_scan_sched_tick_timer.sv
// tick_timer: free-running period timer for the scan scheduler.
// Counts 0..period_i while en_i is high and pulses tick_o for one cycle when
// the count equals period_i, so ticks repeat every period_i+1 cycles.
// The count is held at 0 while en_i is low.
// Ports:
//   clk_i     system clock
//   rst_i     synchronous active-high reset
//   en_i      count enable
//   period_i  tick period minus one
//   tick_o    one-cycle tick pulse
module tick_timer
    import adc_scan_sched_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [PER_W-1:0] period_i,
    output logic             tick_o
);

    logic [PER_W-1:0] count_q;
    logic [PER_W-1:0] count_d;
    logic             at_end;

    assign at_end = (count_q == period_i);
    assign tick_o = en_i && at_end;

    always_comb begin
        count_d = count_q;
        if (!en_i || at_end) begin
            count_d = '0;
        end else begin
            count_d = count_q + PER_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/adc_scan_sched.sv
// adc_scan_sched: periodic two-channel ADC scan scheduler with averaging.
// On each timer tick (while waiting) it pulses stm_o to start the acquisition
// block, captures both channels on eos_i, accumulates 2^navg samples and then
// publishes the truncated averages with a valid/ready handshake. A result
// replaced before being accepted raises the sticky ovr_o flag.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   en_i                scan enable
//   period_i            tick period minus one (clk_i cycles)
//   navg_i              log2 of samples per result, latched on leaving IDLE
//   eos_i, ch0_i, ch1_i end-of-sequence pulse and channel results
//   ready_i             downstream accepts the current result
//   stm_o               one-cycle start pulse to the acquisition block
//   avg0_o, avg1_o      averaged results
//   valid_o             results not yet accepted
//   ovr_o               sticky overrun flag
//   busy_o              FSM outside IDLE
module adc_scan_sched
    import adc_scan_sched_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [PER_W-1:0]  period_i,
    input  logic [NAVG_W-1:0] navg_i,
    input  logic              eos_i,
    input  logic [ADC_W-1:0]  ch0_i,
    input  logic [ADC_W-1:0]  ch1_i,
    input  logic              ready_i,
    output logic              stm_o,
    output logic [ADC_W-1:0]  avg0_o,
    output logic [ADC_W-1:0]  avg1_o,
    output logic              valid_o,
    output logic              ovr_o,
    output logic              busy_o
);

    logic tick;

    tick_timer u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (en_i),
        .period_i (period_i),
        .tick_o   (tick)
    );

    state_t            state_q, state_d;
    logic [NAVG_W-1:0] navg_q, navg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADC_W-1:0]  cap0_q, cap0_d, cap1_q, cap1_d;
    logic [ACC_W-1:0]  acc0_q, acc0_d, acc1_q, acc1_d;
    logic [ADC_W-1:0]  avg0_q, avg0_d, avg1_q, avg1_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;

    always_comb begin
        state_d = state_q;
        navg_d  = navg_q;
        cnt_d   = cnt_q;
        cap0_d  = cap0_q;
        cap1_d  = cap1_q;
        acc0_d  = acc0_q;
        acc1_d  = acc1_q;
        avg0_d  = avg0_q;
        avg1_d  = avg1_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        // Acceptance is evaluated first so that a load in DONE on the same
        // cycle overrides the clear and keeps valid high.
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    state_d = ST_WAIT;
                    navg_d  = navg_i;
                    acc0_d  = '0;
                    acc1_d  = '0;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                // Ticks seen in any other state are simply lost.
                if (!en_i) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (eos_i) begin
                    cap0_d  = ch0_i;
                    cap1_d  = ch1_i;
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                acc0_d = acc0_q + ACC_W'(cap0_q);
                acc1_d = acc1_q + ACC_W'(cap1_q);
                if (cnt_q == last_sample(navg_q)) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                avg0_d  = avg_shift(acc0_q, navg_q);
                avg1_d  = avg_shift(acc1_q, navg_q);
                valid_d = 1'b1;
                // Overwriting an unaccepted result is an overrun unless the
                // old one is being accepted in this very cycle.
                if (valid_q && !ready_i) begin
                    ovr_d = 1'b1;
                end
                acc0_d  = '0;
                acc1_d  = '0;
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            navg_q  <= '0;
            cnt_q   <= '0;
            cap0_q  <= '0;
            cap1_q  <= '0;
            acc0_q  <= '0;
            acc1_q  <= '0;
            avg0_q  <= '0;
            avg1_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            navg_q  <= navg_d;
            cnt_q   <= cnt_d;
            cap0_q  <= cap0_d;
            cap1_q  <= cap1_d;
            acc0_q  <= acc0_d;
            acc1_q  <= acc1_d;
            avg0_q  <= avg0_d;
            avg1_q  <= avg1_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign stm_o   = (state_q == ST_START);
    assign busy_o  = (state_q != ST_IDLE);
    assign avg0_o  = avg0_q;
    assign avg1_o  = avg1_q;
    assign valid_o = valid_q;
    assign ovr_o   = ovr_q;

endmodule

// File: tb/tb_adc_scan_sched.sv
// Self-checking bench for adc_scan_sched: a table of averaging vectors plus
// hand-written sequences for timing, handshake, overrun and reset corners.
module tb_adc_scan_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [28:0] period = 29'd3;
    logic [1:0]  navg = 2'd0;
    logic        eos = 1'b0;
    logic [11:0] ch0 = '0;
    logic [11:0] ch1 = '0;
    logic        ready = 1'b1;
    logic        stm_o, valid_o, ovr_o, busy_o;
    logic [11:0] avg0_o, avg1_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adc_scan_sched dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .en_i     (en),
        .period_i (period),
        .navg_i   (navg),
        .eos_i    (eos),
        .ch0_i    (ch0),
        .ch1_i    (ch1),
        .ready_i  (ready),
        .stm_o    (stm_o),
        .avg0_o   (avg0_o),
        .avg1_o   (avg1_o),
        .valid_o  (valid_o),
        .ovr_o    (ovr_o),
        .busy_o   (busy_o)
    );

    typedef struct packed {
        logic [1:0]       navg;
        logic [1:0]       navg_late;   // applied to navg_i after the first start
        logic [7:0][11:0] s0;          // index 0 is the rightmost element
        logic [7:0][11:0] s1;
        logic [11:0]      e0;
        logic [11:0]      e1;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        eos = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_stm(output int c);
        int n;
        n = 0;
        while (stm_o !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check("stm_seen", {31'd0, stm_o}, 32'd1);
        c = cyc;
    endtask

    // Waits for a start pulse, answers with eos after dly cycles, returns at
    // the start of the ACC cycle.
    task automatic conv(input logic [11:0] c0, input logic [11:0] c1, input int dly,
                        input bit drop_en, output int stm_cyc);
        wait_stm(stm_cyc);
        for (int i = 0; i < dly; i++) begin
            step();
            if (i == 0) begin
                check("stm_width", {31'd0, stm_o}, 32'd0);
                if (drop_en) en = 1'b0;
            end
        end
        eos = 1'b1;
        ch0 = c0;
        ch1 = c1;
        step();
        eos = 1'b0;
        ch0 = '0;
        ch1 = '0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (valid_o !== 1'b1 && n < 6) begin
            step();
            n++;
        end
        check("valid_seen", {31'd0, valid_o}, 32'd1);
    endtask

    initial begin
        int c0, c1, c2, stm_cnt;

        vecs[0] = '{navg: 2'd0, navg_late: 2'd0,
                    s0: {96'd0, 12'h123}, s1: {96'd0, 12'hABC}, e0: 12'h123, e1: 12'hABC};
        vecs[1] = '{navg: 2'd1, navg_late: 2'd1,
                    s0: {72'd0, 12'h101, 12'h100}, s1: {72'd0, 12'h001, 12'hFFF},
                    e0: 12'h100, e1: 12'h800};
        vecs[2] = '{navg: 2'd2, navg_late: 2'd2,
                    s0: {48'd0, 12'd8, 12'd6, 12'd5, 12'd4},
                    s1: {48'd0, {4{12'hFFF}}}, e0: 12'd5, e1: 12'hFFF};
        vecs[3] = '{navg: 2'd3, navg_late: 2'd3,
                    s0: {8{12'hFFF}},
                    s1: {12'd7, 12'd6, 12'd5, 12'd4, 12'd3, 12'd2, 12'd1, 12'd0},
                    e0: 12'hFFF, e1: 12'd3};
        vecs[4] = '{navg: 2'd1, navg_late: 2'd3,
                    s0: {72'd0, 12'h020, 12'h010}, s1: {72'd0, 12'h000, 12'h007},
                    e0: 12'h018, e1: 12'h003};
        vecs[5] = '{navg: 2'd0, navg_late: 2'd2,
                    s0: {84'd0, 12'hFFF}, s1: {84'd0, 12'h000}, e0: 12'hFFF, e1: 12'h000};

        // Reset state
        do_reset();
        check("rst_stm", {31'd0, stm_o}, 32'd0);
        check("rst_avg0", {20'd0, avg0_o}, 32'd0);
        check("rst_avg1", {20'd0, avg1_o}, 32'd0);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_ovr", {31'd0, ovr_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);

        // Table of averaging vectors
        period = 29'd3;
        ready  = 1'b1;
        for (int v = 0; v < 6; v++) begin
            navg = vecs[v].navg;
            step();
            en = 1'b1;
            for (int k = 0; k < (1 << vecs[v].navg); k++) begin
                conv(vecs[v].s0[k], vecs[v].s1[k], 2, 1'b0, c0);
                if (k == 0) navg = vecs[v].navg_late;
            end
            wait_valid();
            check($sformatf("vec%0d_avg0", v), {20'd0, avg0_o}, {20'd0, vecs[v].e0});
            check($sformatf("vec%0d_avg1", v), {20'd0, avg1_o}, {20'd0, vecs[v].e1});
            en = 1'b0;
            step();
            check($sformatf("vec%0d_valid_clr", v), {31'd0, valid_o}, 32'd0);
            step();
            check($sformatf("vec%0d_idle", v), {31'd0, busy_o}, 32'd0);
        end

        // Start spacing with period 9 and eos 5 cycles after start
        do_reset();
        period = 29'd9;
        navg   = 2'd0;
        ready  = 1'b1;
        en     = 1'b1;
        conv(12'h123, 12'hABC, 5, 1'b0, c0);
        wait_valid();
        check("p9_avg0", {20'd0, avg0_o}, 32'h123);
        step();
        check("p9_valid_1cyc", {31'd0, valid_o}, 32'd0);
        conv(12'h123, 12'hABC, 5, 1'b0, c1);
        conv(12'h123, 12'hABC, 5, 1'b0, c2);
        check("p9_spacing_a", c1 - c0, 32'd10);
        check("p9_spacing_b", c2 - c1, 32'd10);
        wait_valid();
        check("p9_avg1", {20'd0, avg1_o}, 32'hABC);

        // Period 0: ticks during a conversion are dropped
        do_reset();
        period = 29'd0;
        en     = 1'b1;
        conv(12'h001, 12'h002, 3, 1'b0, c0);
        conv(12'h001, 12'h002, 3, 1'b0, c1);
        check("p0_spacing", c1 - c0, 32'd7);

        // Overrun with ready held low
        do_reset();
        period = 29'd3;
        ready  = 1'b0;
        en     = 1'b1;
        conv(12'h111, 12'h222, 2, 1'b0, c0);
        step();
        step();
        check("ovr_first_valid", {31'd0, valid_o}, 32'd1);
        check("ovr_first_ovr", {31'd0, ovr_o}, 32'd0);
        conv(12'h333, 12'h444, 2, 1'b0, c0);
        step();
        step();
        check("ovr_avg0", {20'd0, avg0_o}, 32'h333);
        check("ovr_avg1", {20'd0, avg1_o}, 32'h444);
        check("ovr_valid", {31'd0, valid_o}, 32'd1);
        check("ovr_flag", {31'd0, ovr_o}, 32'd1);
        en    = 1'b0;
        ready = 1'b1;
        step();
        step();
        step();
        check("ovr_valid_clr", {31'd0, valid_o}, 32'd0);
        check("ovr_sticky", {31'd0, ovr_o}, 32'd1);

        // Ready pulsed in the DONE cycle of the second result
        do_reset();
        ready = 1'b0;
        en    = 1'b1;
        conv(12'h010, 12'h020, 2, 1'b0, c0);
        step();
        step();
        check("hs_first_valid", {31'd0, valid_o}, 32'd1);
        conv(12'h030, 12'h040, 2, 1'b0, c0);
        step();
        ready = 1'b1;
        step();
        ready = 1'b0;
        check("hs_valid_kept", {31'd0, valid_o}, 32'd1);
        check("hs_avg0", {20'd0, avg0_o}, 32'h030);
        check("hs_no_ovr", {31'd0, ovr_o}, 32'd0);
        step();
        check("hs_valid_hold", {31'd0, valid_o}, 32'd1);
        check("hs_avg1_hold", {20'd0, avg1_o}, 32'h040);
        en    = 1'b0;
        ready = 1'b1;
        step();
        ready = 1'b0;
        check("hs_accept", {31'd0, valid_o}, 32'd0);

        // en dropped in BUSY: conversion still completes, then IDLE
        do_reset();
        ready = 1'b1;
        en    = 1'b1;
        conv(12'h456, 12'h789, 3, 1'b1, c0);
        step();
        step();
        check("drop_valid", {31'd0, valid_o}, 32'd1);
        check("drop_avg0", {20'd0, avg0_o}, 32'h456);
        check("drop_avg1", {20'd0, avg1_o}, 32'h789);
        step();
        check("drop_idle", {31'd0, busy_o}, 32'd0);
        stm_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (stm_o === 1'b1) stm_cnt++;
        end
        check("drop_no_stm", stm_cnt, 32'd0);

        // Reset during BUSY: outputs cleared, late eos ignored
        do_reset();
        ready = 1'b0;
        en    = 1'b1;
        conv(12'h5A5, 12'h1C3, 2, 1'b0, c0);
        step();
        step();
        check("rb_pre_valid", {31'd0, valid_o}, 32'd1);
        wait_stm(c0);
        step();
        rst = 1'b1;
        en  = 1'b0;
        step();
        rst = 1'b0;
        check("rb_avg0", {20'd0, avg0_o}, 32'd0);
        check("rb_avg1", {20'd0, avg1_o}, 32'd0);
        check("rb_valid", {31'd0, valid_o}, 32'd0);
        check("rb_busy", {31'd0, busy_o}, 32'd0);
        check("rb_stm", {31'd0, stm_o}, 32'd0);
        eos = 1'b1;
        ch0 = 12'h777;
        ch1 = 12'h777;
        step();
        eos = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("rb_late_eos_valid", {31'd0, valid_o}, 32'd0);
        check("rb_late_eos_avg0", {20'd0, avg0_o}, 32'd0);
        check("rb_late_eos_busy", {31'd0, busy_o}, 32'd0);
        check("rb_ovr", {31'd0, ovr_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_scan_sched.md
ADC_SCAN_SCHED -- requirements
Module: adc_scan_sched

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk_i  in  1  system clock, single clock domain
- rst_i  in  1  reset, synchronous, active-high
- en_i  in  1  scan enable
- period_i  in  29  tick period minus one, in clk_i cycles
- navg_i  in  2  log2 of samples averaged per result (1/2/4/8)
- eos_i  in  1  end-of-sequence pulse from two-channel SPI acquisition block
- ch0_i  in  12  channel-0 conversion result, valid when eos_i=1
- ch1_i  in  12  channel-1 conversion result, valid when eos_i=1
- ready_i  in  1  downstream (transmitter) accepts result
- stm_o  out  1  one-cycle start pulse to acquisition block
- avg0_o  out  12  averaged channel-0 result
- avg1_o  out  12  averaged channel-1 result
- valid_o  out  1  avg0_o/avg1_o hold an unaccepted result
- ovr_o  out  1  sticky overrun flag
- busy_o  out  1  FSM not in IDLE

Function
REQ-002 Timer SHALL count 0..period_i while en_i=1, asserting tick for one cycle at count==period_i, then wrapping to 0; tick period = period_i+1 cycles (period_i=0 -> tick every cycle); count held at 0 while en_i=0.
REQ-003 FSM SHALL have states IDLE, WAIT, START, BUSY, ACC, DONE.
REQ-004 IDLE: en_i=1 -> WAIT; latch navg_i into navg_q; clear acc0, acc1, sample count.
REQ-005 WAIT: en_i=0 -> IDLE (partial accumulation discarded); else tick -> START.
REQ-006 START: stm_o=1 for exactly this cycle -> BUSY.
REQ-007 BUSY: wait for eos_i; en_i ignored; on eos_i capture ch0_i/ch1_i -> ACC.
REQ-008 ACC: acc0+=ch0, acc1+=ch1 (15-bit unsigned, no overflow possible); if count==2^navg_q-1 -> DONE, else count+1 -> WAIT.
REQ-009 DONE: avg0_o=acc0>>navg_q, avg1_o=acc1>>navg_q (truncating); valid_o=1; acc and count cleared; -> WAIT (which checks en_i next cycle).
REQ-010 Ticks arriving outside WAIT SHALL be dropped, not queued.
REQ-011 Handshake: valid_o clears the cycle after valid_o&ready_i; outputs stable while valid_o=1 and no new load.
REQ-012 New load in DONE with valid_o=1 and ready_i=0: outputs overwritten, valid_o stays 1, ovr_o set sticky.
REQ-013 New load coinciding with ready_i=1: old result counts as accepted, new result loaded, valid_o stays 1, no overrun.
REQ-014 navg_i changes while busy_o=1 SHALL have no effect until next IDLE exit.
REQ-015 Latency eos_i -> valid_o (final sample) SHALL be 3 cycles (capture, ACC, DONE register).

Reset
REQ-016 rst_i=1 at any clock edge SHALL force IDLE, timer=0, acc/count=0, stm_o=0, avg0_o=avg1_o=0, valid_o=0, ovr_o=0, busy_o=0.
REQ-017 Reset mid-BUSY SHALL abandon conversion; the late eos_i seen in IDLE SHALL be ignored.
REQ-018 ovr_o SHALL clear only on reset.

Structure
REQ-019 State encoding and widths (ADC 12, accumulator 15, period 29) SHALL be constants in the shared adc package.
REQ-020 Timer SHALL be a sub-module tick_timer (clk_i, rst_i, en_i, period_i, tick_o).

Verification
REQ-021 period_i=9, navg_i=0, eos_i 5 cycles after stm_o, ch0=0x123, ch1=0xABC, ready_i=1 -> stm_o every 10 cycles, avg0_o=0x123, avg1_o=0xABC, valid_o 1 cycle each result.
REQ-022 navg_i=2, ch0 samples 4,5,6,8, ch1 all 0xFFF -> one result: avg0_o=5, avg1_o=0xFFF.
REQ-023 ready_i=0 throughout, navg_i=0, two conversions -> second values on outputs, valid_o=1, ovr_o=1.
REQ-024 ready_i pulsed in DONE cycle of second result -> valid_o stays 1, ovr_o=0.
REQ-025 en_i dropped in BUSY -> eos_i still accumulated, FSM to IDLE after WAIT, no further stm_o; rst_i asserted in BUSY -> all outputs 0, following eos_i ignored.
REQ-026 period_i=0, eos_i 3 cycles after stm_o -> stm_o spacing 7 cycles (ticks dropped, not queued).
